processing_element: RTL and testbench
=====================================

PROCESSING_ELEMENT -- requirements
Module: processing_element

Interface
REQ-001 The block SHALL have parameter BW, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter SIGNED, default 0: 0 treats operands and accumulator as unsigned; 1 treats them as two's complement.
REQ-003 The block SHALL have parameter SATURATE, default 0: 0 wraps on accumulator overflow; 1 clamps at the range limits.
REQ-004 The block SHALL have port i_clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port i_reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-006 The block SHALL have port i_activation, input, BW bits: activation operand, sampled every cycle.
REQ-007 The block SHALL have port i_weight, input, BW bits: weight operand, sampled every cycle.
REQ-008 The block SHALL have port o_output, output, 2*BW bits: the current accumulator value, driven directly from a register.

Function
REQ-009 The block SHALL hold one 2*BW-bit accumulator register (acc); o_output SHALL equal acc at all times, with no combinational path from any input to o_output.
REQ-010 On each rising edge with i_reset=1, acc SHALL be updated to acc + (i_activation * i_weight).
REQ-011 Latency SHALL be one cycle: operands present before edge N SHALL be reflected in o_output after edge N.
REQ-012 The block SHALL accumulate every cycle; it SHALL have no enable or handshake, and a zero operand SHALL leave acc unchanged.
REQ-013 The product SHALL be the full 2*BW-bit result, computed unsigned when SIGNED=0 and signed (operands sign-extended) when SIGNED=1.
REQ-014 With SATURATE=0, the sum SHALL wrap modulo 2^(2*BW).
REQ-015 With SATURATE=1 and SIGNED=0, any sum exceeding 2^(2*BW)-1 SHALL clamp to all ones.
REQ-016 With SATURATE=1 and SIGNED=1, positive overflow SHALL clamp to 2^(2*BW-1)-1 and negative overflow SHALL clamp to -2^(2*BW-1).
REQ-017 Overflow detection SHALL use one extra guard bit on the sum; the clamped value SHALL persist, and further same-sign products SHALL not change it.
REQ-018 X/Z-free operands SHALL always produce X-free outputs once the block has been out of reset for one edge.

Reset
REQ-019 On a rising edge with i_reset=0, acc SHALL be set to 0 and o_output SHALL read 0 after that edge.
REQ-020 Reset SHALL take priority over accumulation; operands present during reset SHALL be discarded.
REQ-021 Reset asserted mid-accumulation SHALL clear acc on the next edge; the first edge after deassertion SHALL add exactly one product to 0.
REQ-022 Reset SHALL have no asynchronous effect; a reset pulse between clock edges SHALL be ignored.

Verification
REQ-023 BW=8, defaults: hold reset 1 edge, then activation=1, weight=1 -> o_output = 0,1,2,3,4 after successive edges.
REQ-024 BW=8: activation=255, weight=255 for 2 edges -> 65025, then 64514 (130050 mod 65536).
REQ-025 BW=8, SATURATE=1: activation=255, weight=255 for 2 edges -> 65025, then 65535, and 65535 again on the third edge.
REQ-026 BW=8, SIGNED=1, SATURATE=1: activation=-128, weight=127 repeated -> acc decreases by 16256 per edge until clamped at -32768 (0x8000).
REQ-027 Accumulate to 10, then drive i_reset=0 for one edge with activation=3, weight=3 -> o_output=0; release with 3x3 -> 9.
REQ-028 activation=0 with any weight for 5 edges -> o_output unchanged.

Source files
------------

// File: rtl/processing_element.sv
// rtl/processing_element.sv - multiply-accumulate cell with optional signed math and saturation
module processing_element #(
    parameter int BW       = 8,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic [BW-1:0]   i_activation,
    input  logic [BW-1:0]   i_weight,
    output logic [2*BW-1:0] o_output
);

    localparam int AW = 2 * BW;

    logic [AW-1:0] act_ext;
    logic [AW-1:0] wgt_ext;
    logic [AW-1:0] product;
    logic [AW:0]   sum;
    logic          ovf;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_next;

    // Operands are widened to the accumulator width first, so the truncated
    // product is exact for both signed and unsigned interpretation.
    always_comb begin
        act_ext  = '0;
        wgt_ext  = '0;
        product  = '0;
        sum      = '0;
        ovf      = 1'b0;
        acc_next = '0;
        if (SIGNED != 0) begin
            act_ext = {{BW{i_activation[BW-1]}}, i_activation};
            wgt_ext = {{BW{i_weight[BW-1]}}, i_weight};
            product = act_ext * wgt_ext;
            sum     = {acc[AW-1], acc} + {product[AW-1], product};
            ovf     = sum[AW] ^ sum[AW-1];
        end else begin
            act_ext = {{BW{1'b0}}, i_activation};
            wgt_ext = {{BW{1'b0}}, i_weight};
            product = act_ext * wgt_ext;
            sum     = {1'b0, acc} + {1'b0, product};
            ovf     = sum[AW];
        end
        acc_next = sum[AW-1:0];
        // The guard bit carries the true sign of the sum on signed overflow.
        if ((SATURATE != 0) && ovf) begin
            if (SIGNED != 0) begin
                acc_next = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
            end else begin
                acc_next = '1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

    assign o_output = acc;

endmodule

// File: tb/tb_processing_element.sv
// tb/tb_processing_element.sv - randomized bench for processing_element against an arithmetic model
module tb_processing_element;

    logic        clk;
    logic        rst;
    logic [7:0]  act;
    logic [7:0]  wgt;
    logic [15:0] out [4];
    longint      model [4];
    int          total;
    int          bad;

    // cfg index: bit0 = SIGNED, bit1 = SATURATE
    processing_element #(.BW(8), .SIGNED(0), .SATURATE(0)) u_uw (
        .i_clock(clk), .i_reset(rst), .i_activation(act), .i_weight(wgt), .o_output(out[0]));
    processing_element #(.BW(8), .SIGNED(1), .SATURATE(0)) u_sw (
        .i_clock(clk), .i_reset(rst), .i_activation(act), .i_weight(wgt), .o_output(out[1]));
    processing_element #(.BW(8), .SIGNED(0), .SATURATE(1)) u_us (
        .i_clock(clk), .i_reset(rst), .i_activation(act), .i_weight(wgt), .o_output(out[2]));
    processing_element #(.BW(8), .SIGNED(1), .SATURATE(1)) u_ss (
        .i_clock(clk), .i_reset(rst), .i_activation(act), .i_weight(wgt), .o_output(out[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Mathematical value of the accumulator after adding a*w under the given config.
    function automatic longint mac_model(input int cfg, input longint acc,
                                         input logic [7:0] a, input logic [7:0] w);
        longint av, wv, lo, hi, s;
        if (cfg[0]) begin
            av = longint'($signed(a));
            wv = longint'($signed(w));
            lo = -32768;
            hi = 32767;
        end else begin
            av = longint'(a);
            wv = longint'(w);
            lo = 0;
            hi = 65535;
        end
        s = acc + av * wv;
        if (cfg[1]) begin
            if (s > hi) s = hi;
            if (s < lo) s = lo;
        end else begin
            s = s - lo;
            s = ((s % 65536) + 65536) % 65536;
            s = s + lo;
        end
        return s;
    endfunction

    task automatic step(input string tag, input logic [7:0] a, input logic [7:0] w, input logic r);
        logic [15:0] e;
        @(negedge clk);
        act = a;
        wgt = w;
        rst = r;
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            model[c] = r ? mac_model(c, model[c], a, w) : 0;
            e = 16'(model[c]);
            check($sformatf("%s cfg%0d", tag, c), 32'(out[c]), 32'(e));
        end
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] w;
        logic       r;
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        act   = 8'hA5;
        wgt   = 8'h5A;
        for (int c = 0; c < 4; c++) model[c] = 0;

        step("reset", 8'hA5, 8'h5A, 1'b0);
        check("reset_zero", 32'(out[0]), 32'd0);

        for (int i = 1; i <= 4; i++) begin
            step("count", 8'd1, 8'd1, 1'b1);
            check($sformatf("count%0d", i), 32'(out[0]), 32'(i));
        end

        step("clr", 8'd0, 8'd0, 1'b0);
        step("ff1", 8'hFF, 8'hFF, 1'b1);
        check("ff1_wrap", 32'(out[0]), 32'd65025);
        check("ff1_sat", 32'(out[2]), 32'd65025);
        step("ff2", 8'hFF, 8'hFF, 1'b1);
        check("ff2_wrap", 32'(out[0]), 32'd64514);
        check("ff2_sat", 32'(out[2]), 32'd65535);
        step("ff3", 8'hFF, 8'hFF, 1'b1);
        check("ff3_sat", 32'(out[2]), 32'd65535);

        step("clr", 8'd0, 8'd0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step("neg", 8'h80, 8'h7F, 1'b1);
        end
        check("neg_clamp", 32'(out[3]), 32'h8000);
        step("pos", 8'h7F, 8'h7F, 1'b0);
        for (int i = 0; i < 4; i++) step("pos", 8'h7F, 8'h7F, 1'b1);
        check("pos_clamp", 32'(out[3]), 32'h7FFF);

        step("clr", 8'd0, 8'd0, 1'b0);
        step("to10", 8'd2, 8'd5, 1'b1);
        check("to10", 32'(out[0]), 32'd10);
        step("mid_rst", 8'd3, 8'd3, 1'b0);
        check("mid_rst", 32'(out[0]), 32'd0);
        step("after_rst", 8'd3, 8'd3, 1'b1);
        check("after_rst", 32'(out[0]), 32'd9);

        for (int i = 0; i < 5; i++) step("zero_act", 8'd0, 8'($urandom), 1'b1);
        check("zero_hold", 32'(out[0]), 32'd9);

        // A reset pulse that starts and ends between edges must be ignored.
        @(posedge clk);
        #1;
        act = 8'd0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("glitch_now", 32'(out[0]), 32'd9);
        step("glitch", 8'd0, 8'd7, 1'b1);
        check("glitch_after", 32'(out[0]), 32'd9);

        for (int i = 0; i < 2000; i++) begin
            a = 8'($urandom);
            w = 8'($urandom);
            if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'h80;
            if ($urandom_range(0, 3) == 0) w = ($urandom_range(0, 1) == 0) ? 8'h7F : 8'h80;
            if ($urandom_range(0, 7) == 0) a = 8'd0;
            r = ($urandom_range(0, 31) != 0);
            step("rand", a, w, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
